single_cycle_controller: RTL and testbench

SINGLE_CYCLE_CONTROLLER -- requirements
Module: single_cycle_controller

---
 rtl/single_cycle_controller_pkg.sv | 76 +++++++
 rtl/single_cycle_controller_instr_decoder.sv | 70 +++++++
 rtl/single_cycle_controller.sv | 128 ++++++++++++
 tb/tb_single_cycle_controller.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/single_cycle_controller_pkg.sv
// Shared definitions for the single-cycle controller: opcodes, ALU funct
// codes, branch conditions, FSM states, control word and branch test.
package single_cycle_controller_pkg;

   localparam logic [4:0] OP_ALU = 5'b00000;
   localparam logic [4:0] OP_LLI = 5'b00001;
   localparam logic [4:0] OP_LHI = 5'b00010;
   localparam logic [4:0] OP_LDR = 5'b00011;
   localparam logic [4:0] OP_STR = 5'b00101;
   localparam logic [4:0] OP_OUT = 5'b11100;
   localparam logic [4:0] OP_JMP = 5'b10000;
   localparam logic [4:0] OP_JR  = 5'b10001;
   localparam logic [4:0] OP_BCC = 5'b11000;
   localparam logic [4:0] OP_HLT = 5'b11111;

   localparam logic [1:0] FN_ADD = 2'b00;
   localparam logic [1:0] FN_ADC = 2'b01;
   localparam logic [1:0] FN_SUB = 2'b10;
   localparam logic [1:0] FN_SBB = 2'b11;

   localparam logic [2:0] CC_EQ = 3'd0;
   localparam logic [2:0] CC_NE = 3'd1;
   localparam logic [2:0] CC_CS = 3'd2;
   localparam logic [2:0] CC_CC = 3'd3;
   localparam logic [2:0] CC_MI = 3'd4;
   localparam logic [2:0] CC_PL = 3'd5;
   localparam logic [2:0] CC_VS = 3'd6;
   localparam logic [2:0] CC_AL = 3'd7;

   typedef enum logic [1:0] {
      S_LOAD  = 2'd0,
      S_CLEAR = 2'd1,
      S_RUN   = 2'd2,
      S_HALT  = 2'd3
   } state_t;

   typedef struct packed {
      logic adc;
      logic sub;
      logic sbb;
      logic jmp;
      logic branch;
      logic flag_label_pc;
      logic flag_rm_pc;
      logic flag_rd_pc;
      logic src_alu_b;
      logic src_read_b;
      logic data_write_en;
      logic flag_mem_rf;
      logic flag_alu_rf;
      logic flag_rm_rf;
      logic flag_pc_rf;
      logic rf_write_en;
      logic lhi;
      logic lli;
      logic flag_outr;
   } ctrl_t;

   // flags are {C,V,Z,N}
   function automatic logic cond_met(input logic [2:0] cc,
                                     input logic [3:0] flags);
      logic c, v, z, n;
      {c, v, z, n} = flags;
      case (cc)
         CC_EQ:   return z;
         CC_NE:   return !z;
         CC_CS:   return c;
         CC_CC:   return !c;
         CC_MI:   return n;
         CC_PL:   return !n;
         CC_VS:   return v;
         default: return 1'b1;
      endcase
   endfunction

endpackage

// File: rtl/single_cycle_controller_instr_decoder.sv
// Combinational instruction decoder: instr/flags -> control word, ALU and HLT
// markers. Ports: instr, flags (committed {C,V,Z,N}), ctl, is_alu, is_hlt.
module instr_decoder
   import single_cycle_controller_pkg::*;
(
   input  logic [15:0] instr,
   input  logic [3:0]  flags,
   output ctrl_t       ctl,
   output logic        is_alu,
   output logic        is_hlt
);

   logic [4:0] op;
   logic [1:0] fn;

   assign op = instr[15:11];
   assign fn = instr[1:0];

   always_comb begin
      ctl    = '0;
      is_alu = 1'b0;
      is_hlt = 1'b0;
      case (op)
         OP_ALU: begin
            is_alu          = 1'b1;
            ctl.rf_write_en = 1'b1;
            ctl.flag_alu_rf = 1'b1;
            ctl.adc         = (fn == FN_ADC);
            ctl.sub         = (fn == FN_SUB);
            ctl.sbb         = (fn == FN_SBB);
         end
         OP_LLI: begin
            ctl.lli         = 1'b1;
            ctl.rf_write_en = 1'b1;
         end
         OP_LHI: begin
            ctl.lhi         = 1'b1;
            ctl.src_read_b  = 1'b1;
            ctl.rf_write_en = 1'b1;
         end
         OP_LDR: begin
            ctl.src_alu_b   = 1'b1;
            ctl.flag_mem_rf = 1'b1;
            ctl.rf_write_en = 1'b1;
         end
         OP_STR: begin
            ctl.src_alu_b     = 1'b1;
            ctl.src_read_b    = 1'b1;
            ctl.data_write_en = 1'b1;
         end
         OP_OUT: ctl.flag_outr = 1'b1;
         OP_JMP: begin
            ctl.jmp           = 1'b1;
            ctl.flag_label_pc = 1'b1;
         end
         OP_JR: begin
            ctl.jmp        = 1'b1;
            ctl.flag_rm_pc = 1'b1;
         end
         OP_BCC: begin
            // branch decided against the previously committed flags
            ctl.branch        = cond_met(instr[10:8], flags);
            ctl.flag_label_pc = cond_met(instr[10:8], flags);
         end
         OP_HLT: is_hlt = 1'b1;
         default: ;
      endcase
   end

endmodule

// File: rtl/single_cycle_controller.sv
// Single-cycle controller: LOAD/CLEAR/RUN/HALT FSM, commit gating, flag
// register and retired counter around a combinational instruction decoder.
// Ports: clk, clr, start, step_mode, step, mem_instr_out, Pre_* flags in;
// test_normal, dp_clr, flag_HLT, datapath controls, flags_q, retired, state out.
module single_cycle_controller
   import single_cycle_controller_pkg::*;
(
   input  logic        clk,
   input  logic        clr,
   input  logic        start,
   input  logic        step_mode,
   input  logic        step,
   input  logic [15:0] mem_instr_out,
   input  logic        Pre_C,
   input  logic        Pre_V,
   input  logic        Pre_Z,
   input  logic        Pre_N,
   output logic        test_normal,
   output logic        dp_clr,
   output logic        flag_HLT,
   output logic        ADC,
   output logic        SUB,
   output logic        SBB,
   output logic        JMP,
   output logic        BRANCH,
   output logic        flag_label_PC,
   output logic        flag_Rm_PC,
   output logic        flag_Rd_PC,
   output logic        Src_ALU_B,
   output logic        Src_Read_B,
   output logic        data_write_en,
   output logic        flag_mem_RF,
   output logic        flag_ALU_RF,
   output logic        flag_Rm_RF,
   output logic        flag_PC_RF,
   output logic        RF_write_en,
   output logic        LHI,
   output logic        LLI,
   output logic        flag_OutR,
   output logic [3:0]  flags_q,
   output logic [15:0] retired,
   output logic [1:0]  state
);

   state_t cur, nxt;
   ctrl_t  dec, ctl;
   logic   is_alu, is_hlt;
   logic   commit;

   instr_decoder u_dec (
      .instr  (mem_instr_out),
      .flags  (flags_q),
      .ctl    (dec),
      .is_alu (is_alu),
      .is_hlt (is_hlt)
   );

   assign commit = (cur == S_RUN) && (!step_mode || step);

   always_ff @(posedge clk or posedge clr) begin
      if (clr) cur <= S_LOAD;
      else     cur <= nxt;
   end

   always_comb begin
      nxt         = cur;
      ctl         = '0;
      test_normal = 1'b0;
      dp_clr      = 1'b0;
      flag_HLT    = 1'b0;
      case (cur)
         S_LOAD: begin
            test_normal = 1'b1;
            if (start) nxt = S_CLEAR;
         end
         S_CLEAR: begin
            dp_clr = 1'b1;
            nxt    = S_RUN;
         end
         S_RUN: begin
            ctl      = dec;
            flag_HLT = commit;
            // state-changing strobes only fire on a committing cycle
            if (!commit) begin
               ctl.rf_write_en   = 1'b0;
               ctl.data_write_en = 1'b0;
               ctl.flag_outr     = 1'b0;
            end
            if (commit && is_hlt) nxt = S_HALT;
         end
         default: begin
            if (start) nxt = S_LOAD;
         end
      endcase
   end

   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         flags_q <= '0;
         retired <= '0;
      end else if (commit) begin
         retired <= retired + 16'd1;
         if (is_alu) flags_q <= {Pre_C, Pre_V, Pre_Z, Pre_N};
      end
   end

   assign state         = cur;
   assign ADC           = ctl.adc;
   assign SUB           = ctl.sub;
   assign SBB           = ctl.sbb;
   assign JMP           = ctl.jmp;
   assign BRANCH        = ctl.branch;
   assign flag_label_PC = ctl.flag_label_pc;
   assign flag_Rm_PC    = ctl.flag_rm_pc;
   assign flag_Rd_PC    = ctl.flag_rd_pc;
   assign Src_ALU_B     = ctl.src_alu_b;
   assign Src_Read_B    = ctl.src_read_b;
   assign data_write_en = ctl.data_write_en;
   assign flag_mem_RF   = ctl.flag_mem_rf;
   assign flag_ALU_RF   = ctl.flag_alu_rf;
   assign flag_Rm_RF    = ctl.flag_rm_rf;
   assign flag_PC_RF    = ctl.flag_pc_rf;
   assign RF_write_en   = ctl.rf_write_en;
   assign LHI           = ctl.lhi;
   assign LLI           = ctl.lli;
   assign flag_OutR     = ctl.flag_outr;

endmodule

// File: tb/tb_single_cycle_controller.sv
// Directed bench for single_cycle_controller: reset, start/clear/run
// sequencing, decode words, branch flags, step mode, NOP and counter wrap.
module tb_single_cycle_controller;

   logic        clk = 1'b0;
   logic        clr, start, step_mode, step;
   logic [15:0] mem_instr_out;
   logic        Pre_C, Pre_V, Pre_Z, Pre_N;
   logic        test_normal, dp_clr, flag_HLT;
   logic        ADC, SUB, SBB, JMP, BRANCH, flag_label_PC, flag_Rm_PC;
   logic        flag_Rd_PC, Src_ALU_B, Src_Read_B, data_write_en;
   logic        flag_mem_RF, flag_ALU_RF, flag_Rm_RF, flag_PC_RF;
   logic        RF_write_en, LHI, LLI, flag_OutR;
   logic [3:0]  flags_q;
   logic [15:0] retired;
   logic [1:0]  state;
   logic [18:0] ctl;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   single_cycle_controller dut (
      .clk(clk), .clr(clr), .start(start), .step_mode(step_mode),
      .step(step), .mem_instr_out(mem_instr_out),
      .Pre_C(Pre_C), .Pre_V(Pre_V), .Pre_Z(Pre_Z), .Pre_N(Pre_N),
      .test_normal(test_normal), .dp_clr(dp_clr), .flag_HLT(flag_HLT),
      .ADC(ADC), .SUB(SUB), .SBB(SBB), .JMP(JMP), .BRANCH(BRANCH),
      .flag_label_PC(flag_label_PC), .flag_Rm_PC(flag_Rm_PC),
      .flag_Rd_PC(flag_Rd_PC), .Src_ALU_B(Src_ALU_B),
      .Src_Read_B(Src_Read_B), .data_write_en(data_write_en),
      .flag_mem_RF(flag_mem_RF), .flag_ALU_RF(flag_ALU_RF),
      .flag_Rm_RF(flag_Rm_RF), .flag_PC_RF(flag_PC_RF),
      .RF_write_en(RF_write_en), .LHI(LHI), .LLI(LLI),
      .flag_OutR(flag_OutR), .flags_q(flags_q), .retired(retired),
      .state(state)
   );

   assign ctl = {ADC, SUB, SBB, JMP, BRANCH, flag_label_PC, flag_Rm_PC,
                 flag_Rd_PC, Src_ALU_B, Src_Read_B, data_write_en,
                 flag_mem_RF, flag_ALU_RF, flag_Rm_RF, flag_PC_RF,
                 RF_write_en, LHI, LLI, flag_OutR};

   localparam logic [15:0] I_LDR = 16'h1800;
   localparam logic [15:0] I_OUT = 16'hE000;
   localparam logic [15:0] I_ADD = 16'h0018;
   localparam logic [15:0] I_SUB = 16'h0002;
   localparam logic [15:0] I_BEQ = 16'hC000;
   localparam logic [15:0] I_HLT = 16'hF800;
   localparam logic [15:0] I_NOP = 16'h7800;

   localparam logic [18:0] W_LDR = 19'h00488;
   localparam logic [18:0] W_OUT = 19'h00001;
   localparam logic [18:0] W_ADD = 19'h00048;
   localparam logic [18:0] W_SUB = 19'h20048;
   localparam logic [18:0] W_BR  = 19'h06000;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endtask

   // advance to just after the next rising edge
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // LOAD -> CLEAR -> RUN
   task automatic go();
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
   endtask

   logic [15:0] prog [7];
   logic [18:0] word [7];
   logic [15:0] base;
   int          hlt_cnt, rf_bad;

   initial begin
      prog = '{I_LDR, I_OUT, I_LDR, I_OUT, I_ADD, I_OUT, I_HLT};
      word = '{W_LDR, W_OUT, W_LDR, W_OUT, W_ADD, W_OUT, 19'h0};
      clr = 1'b1; start = 1'b0; step_mode = 1'b0; step = 1'b0;
      mem_instr_out = I_LDR;
      {Pre_C, Pre_V, Pre_Z, Pre_N} = 4'b0;
      #12;
      chk("rst_state", 32'(state), 0);
      chk("rst_tn", 32'(test_normal), 1);
      chk("rst_ctl", 32'(ctl), 0);
      chk("rst_ret", 32'(retired), 0);
      clr = 1'b0;
      tick();
      chk("load_hold", 32'(state), 0);

      // step outside RUN is ignored
      step_mode = 1'b1; step = 1'b1;
      tick();
      step = 1'b0; step_mode = 1'b0;
      chk("step_load", 32'(state), 0);

      // start -> one CLEAR cycle -> RUN
      start = 1'b1;
      mem_instr_out = prog[0];
      tick();
      start = 1'b0;
      #1;
      chk("clr_state", 32'(state), 1);
      chk("clr_dp", 32'(dp_clr), 1);
      chk("clr_hlt", 32'(flag_HLT), 0);
      chk("clr_tn", 32'(test_normal), 0);
      chk("clr_ctl", 32'(ctl), 0);
      tick();
      chk("run_state", 32'(state), 2);
      chk("run_dp", 32'(dp_clr), 0);

      // program LDR,OUT,LDR,OUT,ADD,OUT,HLT
      for (int i = 0; i < 7; i++) begin
         mem_instr_out = prog[i];
         start = (i == 2);
         #1;
         chk($sformatf("prog_ctl%0d", i), 32'(ctl), 32'(word[i]));
         chk($sformatf("prog_hlt%0d", i), 32'(flag_HLT), 1);
         tick();
         start = 1'b0;
      end
      #1;
      chk("prog_ret", 32'(retired), 7);
      chk("prog_state", 32'(state), 3);
      chk("halt_hlt", 32'(flag_HLT), 0);
      chk("halt_ctl", 32'(ctl), 0);
      tick();
      chk("halt_ret", 32'(retired), 7);

      // HALT -> LOAD -> RUN, then branch tests
      start = 1'b1;
      tick();
      chk("halt_load", 32'(state), 0);
      go();
      chk("br_run", 32'(state), 2);
      mem_instr_out = I_SUB;
      Pre_Z = 1'b1;
      #1;
      chk("sub_ctl", 32'(ctl), 32'(W_SUB));
      tick();
      Pre_Z = 1'b0;
      chk("sub_flg", 32'(flags_q), 32'h2);
      mem_instr_out = I_BEQ;
      #1;
      chk("beq_t", 32'(ctl), 32'(W_BR));
      tick();
      chk("beq_flg", 32'(flags_q), 32'h2);
      mem_instr_out = I_SUB;
      tick();
      chk("sub2_flg", 32'(flags_q), 32'h0);
      mem_instr_out = I_BEQ;
      #1;
      chk("beq_nt", 32'(ctl), 0);
      tick();

      // step mode: three pulses spaced 4 cycles apart
      base = retired;
      step_mode = 1'b1;
      mem_instr_out = I_LDR;
      #1;
      chk("step_gate", 32'(ctl), 32'(W_LDR & ~19'h8));
      hlt_cnt = 0;
      rf_bad = 0;
      for (int k = 0; k < 12; k++) begin
         step = (k % 4 == 0);
         #1;
         if (flag_HLT) hlt_cnt++;
         if (RF_write_en && !step) rf_bad++;
         tick();
         step = 1'b0;
      end
      chk("step_hlt", 32'(hlt_cnt), 3);
      chk("step_ret", 32'(retired - base), 3);
      chk("step_rf", 32'(rf_bad), 0);
      step_mode = 1'b0;

      // clr mid-RUN with retired=5
      clr = 1'b1;
      #1;
      clr = 1'b0;
      tick();
      go();
      for (int k = 0; k < 5; k++) tick();
      chk("pre_clr_ret", 32'(retired), 5);
      #2;
      Pre_Z = 1'b1;
      mem_instr_out = I_SUB;
      tick();
      Pre_Z = 1'b0;
      chk("pre_clr_flg", 32'(flags_q), 32'h2);
      #2;
      clr = 1'b1;
      #1;
      chk("aclr_state", 32'(state), 0);
      chk("aclr_ret", 32'(retired), 0);
      chk("aclr_flg", 32'(flags_q), 0);
      chk("aclr_tn", 32'(test_normal), 1);
      chk("aclr_ctl", 32'(ctl), 0);
      tick();
      clr = 1'b0;

      // NOP opcode, then counter wrap
      go();
      mem_instr_out = I_NOP;
      #1;
      chk("nop_ctl", 32'(ctl), 0);
      chk("nop_hlt", 32'(flag_HLT), 1);
      tick();
      chk("nop_ret", 32'(retired), 1);
      for (int k = 1; k < 16'hFFFF; k++) tick();
      chk("wrap_pre", 32'(retired), 32'hFFFF);
      tick();
      chk("wrap", 32'(retired), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
